// File: rtl/poly_solver.sv
// Sequential Horner-rule polynomial evaluator: X captured on start, coefficients
// streamed highest order first over valid/ready, one multiply and one add step each.
module poly_solver #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned XWIDTH = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XWIDTH-1:0] x_in,
  input  logic              coef_valid,
  input  logic [WIDTH-1:0]  coef_in,
  output logic              coef_ready,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MUL,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [CW-1:0]    count_q;
  logic             ovf_acc_q;

  logic             busy_next;
  logic             ready_next;
  logic             done_next;

  logic [PW-1:0]    prod;
  logic [SW-1:0]    sum;
  logic             mul_ovf;
  logic             add_carry;
  logic             last_coef;

  // Full-width product and sum so truncation can be flagged.
  assign prod      = PW'(s_q) * PW'(x_q);
  assign sum       = SW'(s_q) + SW'(c_q);
  assign mul_ovf   = |prod[PW-1:WIDTH];
  assign add_carry = sum[WIDTH];
  assign last_coef = (count_q == CW'(DEGREE));

  assign zero = (result == '0);

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      coef_ready <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= busy_next;
      coef_ready <= ready_next;
      done       <= done_next;
    end
  end

  // Next-state decode; outputs are derived from the upcoming state.
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    ready_next = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_WAIT;
      ST_WAIT: if (coef_valid) state_next = ST_MUL;
      ST_MUL:  state_next = ST_ADD;
      ST_ADD:  state_next = last_coef ? ST_DONE : ST_WAIT;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    busy_next  = (state_next != ST_IDLE);
    ready_next = (state_next == ST_WAIT);
    done_next  = (state_next == ST_DONE);
  end

  // Datapath registers; result/overflow only change on the final add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      count_q   <= '0;
      ovf_acc_q <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q       <= WIDTH'(x_in);
            s_q       <= '0;
            count_q   <= '0;
            ovf_acc_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (coef_valid) c_q <= coef_in;
        end
        ST_MUL: begin
          s_q       <= prod[WIDTH-1:0];
          ovf_acc_q <= ovf_acc_q | mul_ovf;
        end
        ST_ADD: begin
          s_q       <= sum[WIDTH-1:0];
          ovf_acc_q <= ovf_acc_q | add_carry;
          count_q   <= count_q + CW'(1);
          if (last_coef) begin
            result   <= sum[WIDTH-1:0];
            overflow <= ovf_acc_q | add_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
